// File: rtl/johnson_decoder.sv
// Johnson-code receive decoder: validates samples, converts to sequence index, tracks lock.
// Optional macro JOHNSON_DEC_HOLD_EN: accept a repeated index (stalled counter) without error.
module johnson_decoder #(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 2,
  parameter int ERR_W    = 8,
  localparam int CW      = $clog2(2*WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] q_in,
  input  logic             in_valid,
  output logic [CW-1:0]    index,
  output logic             index_valid,
  output logic             locked,
  output logic             illegal_code,
  output logic             seq_error,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} state_t;

  state_t           state, state_n;
  logic [3:0]       acq, acq_n;
  logic [4:0]       acq_inc;
  logic [CW-1:0]    prev, prev_n, index_n, dec, expected;
  logic             iv_n, ill_n, seq_n, legal, hold;
  logic [ERR_W-1:0] err_n;
  int unsigned      ones, trans;

  // A Johnson code has at most one 0/1 boundary between adjacent bits.
  always_comb begin
    ones  = 0;
    trans = 0;
    for (int unsigned i = 0; i < WIDTH; i++)
      ones = ones + 32'(q_in[i]);
    for (int unsigned i = 0; i + 1 < WIDTH; i++)
      trans = trans + 32'(q_in[i] ^ q_in[i+1]);
    legal = (trans <= 1);
    if (ones == 0)
      dec = '0;
    else if (q_in[WIDTH-1])
      dec = CW'(ones);
    else
      dec = CW'(2*WIDTH - ones);
  end

  assign expected = (prev == CW'(2*WIDTH-1)) ? '0 : prev + CW'(1);
  assign acq_inc  = {1'b0, acq} + 5'd1;

`ifdef JOHNSON_DEC_HOLD_EN
  assign hold = (dec == prev);
`else
  assign hold = 1'b0;
`endif

  always_comb begin
    state_n = state;
    acq_n   = acq;
    prev_n  = prev;
    index_n = index;
    iv_n    = 1'b0;
    ill_n   = 1'b0;
    seq_n   = 1'b0;
    err_n   = err_count;
    if (in_valid) begin
      if (!legal) begin
        ill_n   = 1'b1;
        state_n = UNLOCKED;
        acq_n   = '0;
      end else begin
        index_n = dec;
        prev_n  = dec;
        iv_n    = 1'b1;
        case (state)
          UNLOCKED: begin
            state_n = ACQUIRE;
            acq_n   = '0;
          end
          ACQUIRE: begin
            if (!hold) begin
              if (dec == expected) begin
                if (acq_inc >= 5'(LOCK_CNT)) begin
                  state_n = LOCKED;
                  acq_n   = '0;
                end else begin
                  acq_n = acq_inc[3:0];
                end
              end else begin
                acq_n = '0;
              end
            end
          end
          LOCKED: begin
            if (!hold && dec != expected) begin
              seq_n   = 1'b1;
              state_n = ACQUIRE;
              acq_n   = '0;
            end
          end
          default: begin
            state_n = UNLOCKED;
            acq_n   = '0;
          end
        endcase
      end
      if ((ill_n || seq_n) && err_count != '1)
        err_n = err_count + ERR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= UNLOCKED;
      acq          <= '0;
      prev         <= '0;
      index        <= '0;
      index_valid  <= 1'b0;
      illegal_code <= 1'b0;
      seq_error    <= 1'b0;
      err_count    <= '0;
    end else begin
      state        <= state_n;
      acq          <= acq_n;
      prev         <= prev_n;
      index        <= index_n;
      index_valid  <= iv_n;
      illegal_code <= ill_n;
      seq_error    <= seq_n;
      err_count    <= err_n;
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_johnson_decoder.sv
// Self-checking bench for johnson_decoder: table-lookup reference model plus directed literal checks.
module tb_johnson_decoder;
  localparam int W    = 4;
  localparam int LOCK = 2;
  localparam int EW   = 2;
  localparam int N    = 2*W;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] q_in = '0;
  logic         in_valid = 1'b0;
  logic [2:0]   index;
  logic         index_valid, locked, illegal_code, seq_error;
  logic [EW-1:0] err_count;

  int n_checks = 0;
  int n_err    = 0;

  johnson_decoder #(.WIDTH(W), .LOCK_CNT(LOCK), .ERR_W(EW)) dut (
    .clk(clk), .rst(rst), .q_in(q_in), .in_valid(in_valid),
    .index(index), .index_valid(index_valid), .locked(locked),
    .illegal_code(illegal_code), .seq_error(seq_error), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Johnson code for sequence position n, built from its definition.
  function automatic logic [W-1:0] codeof(input int n);
    logic [W-1:0] c;
    for (int i = 0; i < W; i++)
      c[i] = (n <= W) ? (i >= W - n) : (i < N - n);
    return c;
  endfunction

  function automatic int lookup(input logic [W-1:0] q);
    for (int n = 0; n < N; n++)
      if (codeof(n) == q) return n;
    return -1;
  endfunction

  // Reference model: state 0=UNLOCKED, 1=ACQUIRE, 2=LOCKED.
  int m_state, m_acq, m_prev, m_index, m_err;
  bit m_iv, m_ill, m_seq, m_init = 0;
`ifdef JOHNSON_DEC_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  always @(posedge clk) begin
    int idx;
    if (rst) begin
      m_state = 0; m_acq = 0; m_prev = 0; m_index = 0; m_err = 0;
      m_iv = 0; m_ill = 0; m_seq = 0; m_init = 1;
    end else begin
      m_iv = 0; m_ill = 0; m_seq = 0;
      if (in_valid) begin
        idx = lookup(q_in);
        if (idx < 0) begin
          m_ill = 1; m_state = 0; m_acq = 0;
        end else begin
          m_index = idx; m_iv = 1;
          if (m_state == 0) begin
            m_state = 1; m_acq = 0;
          end else if (HOLD && idx == m_prev) begin
            // stalled counter: nothing changes
          end else if (idx == (m_prev + 1) % N) begin
            if (m_state == 1) begin
              m_acq++;
              if (m_acq == LOCK) begin m_state = 2; m_acq = 0; end
            end
          end else begin
            if (m_state == 2) m_seq = 1;
            m_state = 1; m_acq = 0;
          end
          m_prev = idx;
        end
        if ((m_ill || m_seq) && m_err < (1 << EW) - 1) m_err++;
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      n_checks++;
      if (int'(index) != m_index || index_valid != m_iv || locked != (m_state == 2) ||
          illegal_code != m_ill || seq_error != m_seq || int'(err_count) != m_err) begin
        n_err++;
        $display("FAIL model t=%0t: got idx=%0d iv=%0b lk=%0b ill=%0b seq=%0b err=%0d, expected idx=%0d iv=%0b lk=%0b ill=%0b seq=%0b err=%0d",
                 $time, index, index_valid, locked, illegal_code, seq_error, err_count,
                 m_index, m_iv, (m_state == 2), m_ill, m_seq, m_err);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic [W-1:0] q, input logic v);
    q_in = q; in_valid = v;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [W-1:0] ill_codes [5];
    int cur, r, nxt;
    ill_codes = '{4'b1010, 4'b0101, 4'b1001, 4'b0110, 4'b1101};

    do_reset();
    chk("reset_index", int'(index), 0);
    chk("reset_valid", int'(index_valid), 0);
    chk("reset_locked", int'(locked), 0);
    chk("reset_err", int'(err_count), 0);

    // Lock-up
    drive(4'b0000, 1); chk("lock_idx0", int'(index), 0); chk("lock_iv0", int'(index_valid), 1);
    drive(4'b1000, 1); chk("lock_idx1", int'(index), 1); chk("lock_lk1", int'(locked), 0);
    drive(4'b1100, 1); chk("lock_idx2", int'(index), 2); chk("lock_lk2", int'(locked), 1);
    chk("lock_err", int'(err_count), 0);

    // Wrap-around
    drive(4'b1110, 1); drive(4'b1111, 1); drive(4'b0111, 1);
    drive(4'b0011, 1); chk("wrap_idx6", int'(index), 6);
    drive(4'b0001, 1); chk("wrap_idx7", int'(index), 7);
    drive(4'b0000, 1); chk("wrap_idx0", int'(index), 0); chk("wrap_lk", int'(locked), 1);
    drive(4'b1000, 1); chk("wrap_idx1", int'(index), 1); chk("wrap_seq", int'(seq_error), 0);

    // Illegal code while locked
    drive(4'b1010, 1);
    chk("ill_pulse", int'(illegal_code), 1); chk("ill_lk", int'(locked), 0);
    chk("ill_idx", int'(index), 1); chk("ill_iv", int'(index_valid), 0);
    chk("ill_err", int'(err_count), 1);
    drive(4'b0000, 0); chk("ill_pulse_end", int'(illegal_code), 0); chk("ill_hold_idx", int'(index), 1);

    // Skip detection
    drive(4'b0000, 1); drive(4'b1000, 1); drive(4'b1100, 1);
    chk("skip_pre_lk", int'(locked), 1);
    drive(4'b1111, 1);
    chk("skip_seq", int'(seq_error), 1); chk("skip_idx", int'(index), 4);
    chk("skip_lk", int'(locked), 0); chk("skip_err", int'(err_count), 2);
    drive(4'b0111, 1); chk("relock_seq", int'(seq_error), 0); chk("relock_lk5", int'(locked), 0);
    drive(4'b0011, 1); chk("relock_lk6", int'(locked), 1); chk("relock_idx", int'(index), 6);

    // Saturation with gaps
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(ill_codes[i], 1);
      chk("sat_err", int'(err_count), (i < 3) ? i + 1 : 3);
      drive(4'b0000, 0);
      chk("gap_ill", int'(illegal_code), 0);
      chk("gap_idx", int'(index), 0);
    end

    // Reset coinciding with a valid sample
    drive(4'b0000, 1); drive(4'b1000, 1); drive(4'b1100, 1);
    rst = 1'b1; q_in = 4'b1110; in_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    chk("rstmid_idx", int'(index), 0); chk("rstmid_iv", int'(index_valid), 0);
    chk("rstmid_lk", int'(locked), 0); chk("rstmid_err", int'(err_count), 0);

    // Repeated index while locked
    drive(4'b0000, 1); drive(4'b1000, 1); drive(4'b1100, 1);
    drive(4'b1100, 1);
    chk("rep_iv", int'(index_valid), 1); chk("rep_idx", int'(index), 2);
`ifdef JOHNSON_DEC_HOLD_EN
    chk("rep_seq", int'(seq_error), 0); chk("rep_lk", int'(locked), 1);
    drive(4'b1100, 1); chk("rep2_lk", int'(locked), 1);
`else
    chk("rep_seq", int'(seq_error), 1); chk("rep_lk", int'(locked), 0);
    drive(4'b1100, 1); chk("rep2_seq", int'(seq_error), 0); chk("rep2_err", int'(err_count), 1);
`endif

    // Mixed traffic checked by the model only
    do_reset();
    cur = 0;
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 5)      begin nxt = (cur + 1) % N; drive(codeof(nxt), 1); cur = nxt; end
      else if (r == 6) drive(codeof(cur), 1);
      else if (r == 7) begin nxt = (cur + 2) % N; drive(codeof(nxt), 1); cur = nxt; end
      else if (r == 8) drive(W'($urandom_range(0, 15)), 1);
      else             drive(codeof(cur), 0);
      if (i % 100 == 99) do_reset();
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/johnson_decoder.md
Name: johnson_decoder

Overview:
Receive end of the Johnson-counter code path. Samples a WIDTH-bit Johnson code stream, validates each code, converts it to a binary sequence index, and checks that consecutive samples advance by exactly one step. Sits downstream of a Johnson counter or a bus carrying its state. Provides lock status and error flags, and keeps a saturating error tally for monitoring logic.

Parameters:
WIDTH, 4, Johnson code width; sequence length is 2*WIDTH; legal range 2..16.
LOCK_CNT, 2, consecutive correct advances needed to go from ACQUIRE to LOCKED; legal range 1..15.
ERR_W, 8, width of the saturating error counter.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous reset, active-high.
q_in  input  WIDTH  Johnson code sample; q_in[WIDTH-1] is the stage fed by the inverted LSB.
in_valid  input  1  q_in is sampled on a clock edge where in_valid=1.
index  output  CW  decoded sequence index, CW=$clog2(2*WIDTH); registered.
index_valid  output  1  one-cycle pulse: index is updated from a legal sample.
locked  output  1  high in the LOCKED state.
illegal_code  output  1  one-cycle pulse: the sampled code is not a Johnson code.
seq_error  output  1  one-cycle pulse: legal code but wrong step while LOCKED.
err_count  output  ERR_W  saturating count of illegal_code plus seq_error events.

Behaviour:
- Reset (rst=1 at a clock edge) sets: index=0, index_valid=0, locked=0, illegal_code=0, seq_error=0, err_count=0, state=UNLOCKED, acquire counter=0, prev index=0. Reset takes priority over everything, including a sample in the same cycle.
- Legal code: either a run of ones from the MSB followed by zeros (1..10..0, including all-zero), or a run of zeros from the MSB followed by ones (0..01..1, including all-ones). Any other pattern is illegal.
- Decode, with k = number of ones: all-zero gives 0; MSB=1 gives k; MSB=0 and k>0 gives 2*WIDTH-k. For WIDTH=4: 0000->0, 1000->1, 1100->2, 1110->3, 1111->4, 0111->5, 0011->6, 0001->7.
- Expected next index = (prev+1) mod 2*WIDTH. Index 7 wraps to 0 for WIDTH=4.
- Latency: all outputs are registered and reflect the sample one cycle after the in_valid edge. Pulses last exactly one cycle. With in_valid=0, outputs other than the pulses hold and the pulses are 0.
- FSM states: UNLOCKED, ACQUIRE, LOCKED. All transitions happen only on valid samples.
  - Any state, illegal sample: illegal_code=1, index_valid=0, index and prev unchanged, next state UNLOCKED, acquire counter cleared.
  - UNLOCKED, legal sample: prev=decoded value, index updated, index_valid=1, next state ACQUIRE, acquire counter=0.
  - ACQUIRE, legal sample equal to expected: acquire counter+1; when it reaches LOCK_CNT, go to LOCKED.
  - ACQUIRE, legal sample not equal to expected: acquire counter=0, stay in ACQUIRE, no seq_error.
  - ACQUIRE: index and prev are updated on every legal sample.
  - LOCKED, legal sample equal to expected: index updated, index_valid=1.
  - LOCKED, legal sample not equal to expected: seq_error=1, index updated, index_valid=1, next state ACQUIRE, acquire counter=0.
- locked=1 exactly while the registered state is LOCKED.
- err_count increments by 1 per illegal_code or seq_error event. The two events are mutually exclusive per sample. The count saturates at 2^ERR_W-1 and clears only on rst.

Optional Feature:
Macro JOHNSON_DEC_HOLD_EN.
- Defined: a legal sample equal to prev (counter stalled) is accepted in ACQUIRE and LOCKED. It produces index_valid=1 and no error. The state and acquire counter are unchanged.
- Not defined: a repeated index is treated as a wrong step. In LOCKED this gives seq_error and a drop to ACQUIRE. In ACQUIRE it clears the acquire counter.

Test Plan:
- Lock-up: WIDTH=4, LOCK_CNT=2, reset, then feed 0000,1000,1100 with in_valid every cycle -> index 0,1,2, each with index_valid; locked=1 one cycle after the 1100 sample; err_count=0.
- Wrap-around: while LOCKED, feed 0011,0001,0000,1000 -> index 6,7,0,1; locked stays 1; no error pulses.
- Illegal code: while LOCKED, feed 1010 -> illegal_code pulse, locked=0, index holds its previous value, err_count=1.
- Skip detection: while LOCKED at index 2, feed 1111 (index 4) -> seq_error pulse, index=4, state ACQUIRE, err_count+1; then 0111 and 0011 -> relock.
- Gaps and saturation: with ERR_W=2, feed 5 illegal codes separated by in_valid=0 cycles -> err_count reaches 3 and holds at 3; outputs hold during the gaps.
- Reset mid-operation and hold: assert rst on the same edge as a valid 1110 -> all outputs return to reset values. With JOHNSON_DEC_HOLD_EN, while LOCKED feed 1100,1100 -> second sample gives no seq_error and locked stays 1. Without the macro -> seq_error and locked=0.
